// File: rtl/cpu_fetch_stage.sv
// Instruction fetch: combinational pre-fetch picks nextpc and issues the SRAM read; a fetch register holds the PC.
// A one-entry buffer holds the instruction over decode stalls, and a branch seen while stalled is held until fetch advances.
module cpu_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ds_allowin,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst
);

  localparam logic [31:0] PRE_RESET_PC = RESET_PC - 32'd4;

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;

  logic        fs_allowin;
  logic [31:0] nextpc;

  assign fs_allowin = !fs_valid_q || ds_allowin;

  // A branch in the current cycle outranks one that arrived during an earlier stall cycle.
  assign nextpc = br_taken     ? br_target :
                  pend_valid_q ? pend_target_q :
                                 fs_pc_q + 32'd4;

  assign inst_sram_en    = fs_allowin && !resetn;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wen   = 4'b0;
  assign inst_sram_wdata = 32'b0;

  assign fs_to_ds_valid = fs_valid_q;
  assign fs_pc          = fs_pc_q;
  assign fs_inst        = buf_valid_q ? inst_buf_q : inst_sram_rdata;

  always_comb begin
    fs_valid_d    = fs_valid_q;
    fs_pc_d       = fs_pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    buf_valid_d   = buf_valid_q;
    inst_buf_d    = inst_buf_q;

    if (fs_allowin) begin
      fs_valid_d   = 1'b1;
      fs_pc_d      = nextpc;
      pend_valid_d = 1'b0;
    end else if (br_taken) begin
      pend_valid_d  = 1'b1;
      pend_target_d = br_target;
    end

    // SRAM data lives for one cycle only, so catch it on the first stalled edge.
    if (ds_allowin) begin
      buf_valid_d = 1'b0;
    end else if (fs_valid_q && !buf_valid_q) begin
      buf_valid_d = 1'b1;
      inst_buf_d  = inst_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      fs_valid_q    <= 1'b0;
      fs_pc_q       <= PRE_RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'b0;
      buf_valid_q   <= 1'b0;
      inst_buf_q    <= 32'b0;
    end else begin
      fs_valid_q    <= fs_valid_d;
      fs_pc_q       <= fs_pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      buf_valid_q   <= buf_valid_d;
      inst_buf_q    <= inst_buf_d;
    end
  end

endmodule

// File: tb/tb_cpu_fetch_stage.sv
// Bench for cpu_fetch_stage: directed vector table, hand-written reset sequence, then random stalls/branches against a PC-stream model.
module tb_cpu_fetch_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ds_allowin;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;

  int n_total = 0;
  int n_pass  = 0;

  cpu_fetch_stage #(.RESET_PC(32'hBFC00000)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .ds_allowin      (ds_allowin),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_pc           (fs_pc),
    .fs_inst         (fs_inst)
  );

  always #5 clk = ~clk;

  // SRAM returns the address as data; without a read its output is junk.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_sram_addr;
    else              inst_sram_rdata <= {16'hDEAD, 16'($urandom)};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        ds;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_en;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[19];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] m_pc;
  logic [31:0] m_next;
  logic        r_ds;
  logic        r_br;
  logic [31:0] r_tgt;

  initial begin
    vecs[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'hBFBFFFFC, 1'b1, 32'hBFC00000};
    vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hBFC00000, 1'b1, 32'hBFC00004};
    vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hBFC00004, 1'b1, 32'hBFC00008};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hBFC00008, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hBFC00008, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hBFC00008, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hBFC00008, 1'b1, 32'hBFC0000C};
    vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hBFC0000C, 1'b1, 32'hBFC00010};
    vecs[8]  = '{1'b1, 32'hBFC00100, 1'b1, 1'b1, 32'hBFC00010, 1'b1, 32'hBFC00100};
    vecs[9]  = '{1'b1, 32'hBFC00180, 1'b0, 1'b1, 32'hBFC00100, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'hBFC00200, 1'b0, 1'b1, 32'hBFC00100, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hBFC00100, 1'b1, 32'hBFC00200};
    vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hBFC00200, 1'b1, 32'hBFC00204};
    vecs[13] = '{1'b1, 32'hBFC00300, 1'b0, 1'b1, 32'hBFC00204, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 32'hBFC00400, 1'b1, 1'b1, 32'hBFC00204, 1'b1, 32'hBFC00400};
    vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hBFC00400, 1'b1, 32'hBFC00404};
    vecs[16] = '{1'b1, 32'hFFFFFFFC, 1'b1, 1'b1, 32'hBFC00404, 1'b1, 32'hFFFFFFFC};
    vecs[17] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFC, 1'b1, 32'h00000000};
    vecs[18] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h00000000, 1'b1, 32'h00000004};

    resetn     = 1'b1;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    ds_allowin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", 32'(fs_to_ds_valid), 32'h0);
    chk("reset pc",    fs_pc,               32'hBFBFFFFC);
    chk("reset en",    32'(inst_sram_en),   32'h0);
    chk("reset wen",   32'(inst_sram_wen),  32'h0);
    chk("reset wdata", inst_sram_wdata,     32'h0);

    resetn = 1'b0;
    for (int i = 0; i < 19; i++) begin
      br_taken   = vecs[i].br;
      br_target  = vecs[i].tgt;
      ds_allowin = vecs[i].ds;
      #1;
      chk($sformatf("vec%0d valid", i), 32'(fs_to_ds_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d pc", i), fs_pc, vecs[i].exp_pc);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d inst", i), fs_inst, vecs[i].exp_pc);
      chk($sformatf("vec%0d en", i), 32'(inst_sram_en), 32'(vecs[i].exp_en));
      if (vecs[i].exp_en) chk($sformatf("vec%0d addr", i), inst_sram_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d wen", i), 32'(inst_sram_wen), 32'h0);
      next_cycle();
    end

    // Reset during a stall with a pending branch and a buffered instruction.
    br_taken   = 1'b1;
    br_target  = 32'hBFC00500;
    ds_allowin = 1'b0;
    next_cycle();
    br_taken = 1'b0;
    #1;
    resetn = 1'b1;
    #1;
    chk("midrst valid", 32'(fs_to_ds_valid), 32'h0);
    chk("midrst en",    32'(inst_sram_en),   32'h0);
    chk("midrst pc",    fs_pc,               32'hBFBFFFFC);
    next_cycle();
    chk("midrst hold valid", 32'(fs_to_ds_valid), 32'h0);
    resetn     = 1'b0;
    ds_allowin = 1'b1;
    #1;
    chk("restart en",   32'(inst_sram_en), 32'h1);
    chk("restart addr", inst_sram_addr,    32'hBFC00000);
    next_cycle();
    ds_allowin = 1'b0;
    #1;
    chk("restart pc",    fs_pc,                32'hBFC00000);
    chk("restart inst",  fs_inst,              32'hBFC00000);
    chk("restart valid", 32'(fs_to_ds_valid),  32'h1);
    next_cycle();
    chk("restart stall inst", fs_inst, 32'hBFC00000);

    // Random stalls and branches; the model tracks only the expected PC stream.
    m_pc   = 32'hBFC00000;
    m_next = 32'hBFC00004;
    for (int c = 0; c < 400; c++) begin
      r_ds  = ($urandom_range(0, 2) != 0);
      r_br  = ($urandom_range(0, 3) == 0);
      r_tgt = {$urandom} & 32'hFFFFFFFC;
      if ($urandom_range(0, 7) == 0) r_tgt = 32'hFFFFFFF8;
      ds_allowin = r_ds;
      br_taken   = r_br;
      br_target  = r_tgt;
      if (r_br) m_next = r_tgt;
      #1;
      chk($sformatf("rnd%0d valid", c), 32'(fs_to_ds_valid), 32'h1);
      chk($sformatf("rnd%0d pc", c),    fs_pc,               m_pc);
      chk($sformatf("rnd%0d inst", c),  fs_inst,             m_pc);
      chk($sformatf("rnd%0d en", c),    32'(inst_sram_en),   32'(r_ds));
      if (r_ds) chk($sformatf("rnd%0d addr", c), inst_sram_addr, m_next);
      next_cycle();
      if (r_ds) begin
        m_pc   = m_next;
        m_next = m_pc + 32'd4;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
